// File: rtl/instruction_cache.sv
// Direct-mapped, read-only instruction cache with a single outstanding L2 line refill.
// Optional hit/miss counters are compiled in when ICACHE_PERF_COUNTER_EN is defined.
module instruction_cache #(
    parameter int ADDRESS_WIDTH  = 32,
    parameter int WORD_SIZE      = 4,
    parameter int WORD_PER_BLOCK = 16,
    parameter int CACHE_DEPTH    = 64,
    parameter int L2_BUS_WIDTH   = 32,
    localparam int WORD_W              = 8 * WORD_SIZE,
    localparam int BLOCK_WIDTH         = WORD_W * WORD_PER_BLOCK,
    localparam int BYTE_BITS           = $clog2(WORD_SIZE),
    localparam int OFFSET_BITS         = $clog2(WORD_PER_BLOCK),
    localparam int INDEX_BITS          = $clog2(CACHE_DEPTH),
    localparam int BLOCK_ADDRESS_WIDTH = ADDRESS_WIDTH - OFFSET_BITS - BYTE_BITS,
    localparam int TAG_WIDTH           = BLOCK_ADDRESS_WIDTH - INDEX_BITS
) (
    input  logic                           CLK,
    input  logic                           RST_N,
    input  logic                           STALL_INSTRUCTION_CACHE,
    input  logic [ADDRESS_WIDTH-1:0]       PC,
    input  logic                           PC_VALID,
    output logic [WORD_W-1:0]              INSTRUCTION,
    output logic                           INSTRUCTION_CACHE_READY,
    input  logic                           ADDRESS_TO_L2_READY_INSTRUCTION_CACHE,
    output logic                           ADDRESS_TO_L2_VALID_INSTRUCTION_CACHE,
    output logic [BLOCK_ADDRESS_WIDTH-1:0] ADDRESS_TO_L2_INSTRUCTION_CACHE,
    output logic                           DATA_FROM_L2_READY_INSTRUCTION_CACHE,
    input  logic                           DATA_FROM_L2_VALID_INSTRUCTION_CACHE,
    input  logic [BLOCK_WIDTH-1:0]         DATA_FROM_L2_INSTRUCTION_CACHE
`ifdef ICACHE_PERF_COUNTER_EN
    ,
    output logic [31:0]                    HIT_COUNT,
    output logic [31:0]                    MISS_COUNT
`endif
);

    // Element 0 is the leftmost (most significant) word of the line.
    typedef logic [0:WORD_PER_BLOCK-1][WORD_W-1:0] line_t;
    typedef enum logic [1:0] {IDLE, REQ, WAIT_DATA, RESPOND} state_e;

    state_e                           state_q;
    logic [CACHE_DEPTH-1:0]           valid_q;
    logic [TAG_WIDTH-1:0]             tag_q  [CACHE_DEPTH];
    line_t                            data_q [CACHE_DEPTH];
    logic [ADDRESS_WIDTH-1:0]         miss_pc_q;
    logic [WORD_W-1:0]                instruction_q;
    logic                             ready_q;
    logic                             addr_valid_q;
    logic [BLOCK_ADDRESS_WIDTH-1:0]   addr_q;
    logic                             data_ready_q;

    logic [OFFSET_BITS-1:0] pc_offset, miss_offset;
    logic [INDEX_BITS-1:0]  pc_index, miss_index;
    logic [TAG_WIDTH-1:0]   pc_tag, miss_tag;
    logic                   lookup, hit, refill_beat;
    line_t                  lookup_line, refill_line;

    assign pc_offset   = PC[BYTE_BITS +: OFFSET_BITS];
    assign pc_index    = PC[BYTE_BITS + OFFSET_BITS +: INDEX_BITS];
    assign pc_tag      = PC[ADDRESS_WIDTH-1 -: TAG_WIDTH];
    assign miss_offset = miss_pc_q[BYTE_BITS +: OFFSET_BITS];
    assign miss_index  = miss_pc_q[BYTE_BITS + OFFSET_BITS +: INDEX_BITS];
    assign miss_tag    = miss_pc_q[ADDRESS_WIDTH-1 -: TAG_WIDTH];

    assign lookup      = (state_q == IDLE) && PC_VALID && !STALL_INSTRUCTION_CACHE;
    assign hit         = valid_q[pc_index] && (tag_q[pc_index] == pc_tag);
    assign refill_beat = (state_q == WAIT_DATA) && DATA_FROM_L2_VALID_INSTRUCTION_CACHE;
    assign lookup_line = data_q[pc_index];
    assign refill_line = data_q[miss_index];

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q       <= IDLE;
            valid_q       <= '0;
            miss_pc_q     <= '0;
            instruction_q <= '0;
            ready_q       <= 1'b0;
            addr_valid_q  <= 1'b0;
            addr_q        <= '0;
            data_ready_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (lookup) begin
                        if (hit) begin
                            instruction_q <= lookup_line[pc_offset];
                            ready_q       <= 1'b1;
                        end else begin
                            ready_q      <= 1'b0;
                            miss_pc_q    <= PC;
                            addr_q       <= PC[ADDRESS_WIDTH-1 -: BLOCK_ADDRESS_WIDTH];
                            addr_valid_q <= 1'b1;
                            state_q      <= REQ;
                        end
                    end
                end
                // The L2 handshake keeps running while stalled; only the response waits.
                REQ: begin
                    if (ADDRESS_TO_L2_READY_INSTRUCTION_CACHE) begin
                        addr_valid_q <= 1'b0;
                        data_ready_q <= 1'b1;
                        state_q      <= WAIT_DATA;
                    end
                end
                WAIT_DATA: begin
                    if (DATA_FROM_L2_VALID_INSTRUCTION_CACHE) begin
                        valid_q[miss_index] <= 1'b1;
                        data_ready_q        <= 1'b0;
                        state_q             <= RESPOND;
                    end
                end
                RESPOND: begin
                    if (!STALL_INSTRUCTION_CACHE) begin
                        instruction_q <= refill_line[miss_offset];
                        ready_q       <= 1'b1;
                        state_q       <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // NOTE: tag/data arrays carry no reset; the valid bits alone decide whether a line is usable.
    always_ff @(posedge CLK) begin
        if (refill_beat) begin
            tag_q[miss_index]  <= miss_tag;
            data_q[miss_index] <= DATA_FROM_L2_INSTRUCTION_CACHE;
        end
    end

    assign INSTRUCTION                           = instruction_q;
    assign INSTRUCTION_CACHE_READY               = ready_q;
    assign ADDRESS_TO_L2_VALID_INSTRUCTION_CACHE = addr_valid_q;
    assign ADDRESS_TO_L2_INSTRUCTION_CACHE       = addr_q;
    assign DATA_FROM_L2_READY_INSTRUCTION_CACHE  = data_ready_q;

`ifdef ICACHE_PERF_COUNTER_EN
    logic [31:0] hit_count_q, miss_count_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else if (lookup) begin
            if (hit && hit_count_q != '1) begin
                hit_count_q <= hit_count_q + 32'd1;
            end
            if (!hit && miss_count_q != '1) begin
                miss_count_q <= miss_count_q + 32'd1;
            end
        end
    end

    assign HIT_COUNT  = hit_count_q;
    assign MISS_COUNT = miss_count_q;
`else
    // Counters compiled out.
`endif

    logic unused_bits;
    assign unused_bits = ^{PC[BYTE_BITS-1:0], miss_pc_q[BYTE_BITS-1:0], L2_BUS_WIDTH};

endmodule

// File: tb/tb_instruction_cache.sv
// Randomized bench for instruction_cache: a line-residency model plus a synthetic L2
// (line contents are a pure function of the line address) predict every output.
module tb_instruction_cache;

    logic         CLK = 1'b0;
    logic         RST_N = 1'b0;
    logic         STALL = 1'b0;
    logic [31:0]  PC = '0;
    logic         PC_VALID = 1'b0;
    logic         ADDR_READY = 1'b0;
    logic         DATA_VALID = 1'b0;
    logic [511:0] DATA = '0;
    logic [31:0]  INSTRUCTION;
    logic         READY;
    logic         ADDR_VALID;
    logic [25:0]  ADDR;
    logic         DATA_READY;
`ifdef ICACHE_PERF_COUNTER_EN
    logic [31:0]  HIT_COUNT, MISS_COUNT;
`endif

    instruction_cache dut (
        .CLK                                   (CLK),
        .RST_N                                 (RST_N),
        .STALL_INSTRUCTION_CACHE               (STALL),
        .PC                                    (PC),
        .PC_VALID                              (PC_VALID),
        .INSTRUCTION                           (INSTRUCTION),
        .INSTRUCTION_CACHE_READY               (READY),
        .ADDRESS_TO_L2_READY_INSTRUCTION_CACHE (ADDR_READY),
        .ADDRESS_TO_L2_VALID_INSTRUCTION_CACHE (ADDR_VALID),
        .ADDRESS_TO_L2_INSTRUCTION_CACHE       (ADDR),
        .DATA_FROM_L2_READY_INSTRUCTION_CACHE  (DATA_READY),
        .DATA_FROM_L2_VALID_INSTRUCTION_CACHE  (DATA_VALID),
        .DATA_FROM_L2_INSTRUCTION_CACHE        (DATA)
`ifdef ICACHE_PERF_COUNTER_EN
        ,
        .HIT_COUNT                             (HIT_COUNT),
        .MISS_COUNT                            (MISS_COUNT)
`endif
    );

    always #5 CLK = ~CLK;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] exp_instr = '0;
    logic        exp_ready = 1'b0;
    bit          res_valid [64];
    logic [25:0] res_line [64];
    int          model_hits = 0;
    int          model_misses = 0;

    // Synthetic L2 contents; line 0 word 0 is the cold-miss opcode.
    function automatic logic [31:0] l2_word(input logic [25:0] la, input int k);
        if (la == 26'd0 && k == 0) return 32'h0000_0093;
        return ({6'd0, la} * 32'h9E37_79B1) ^ (32'(k) << 24) ^ 32'h0013_0000 ^ 32'(k);
    endfunction

    function automatic logic [511:0] line_for(input logic [25:0] la);
        logic [511:0] line;
        for (int k = 0; k < 16; k++) line[511 - 32*k -: 32] = l2_word(la, k);
        return line;
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 64; i++) res_valid[i] = 1'b0;
        exp_instr    = '0;
        exp_ready    = 1'b0;
        model_hits   = 0;
        model_misses = 0;
    endtask

    // One fetch from request to delivered word, with configurable L2 latencies and stall.
    task automatic fetch(input logic [31:0] pc, input int addr_wait, input int data_wait,
                         input int stall_cycles);
        logic [25:0] la;
        int idx, off;
        bit hit;
        la  = pc[31:6];
        idx = int'(pc[11:6]);
        off = int'(pc[5:2]);
        hit = res_valid[idx] && res_line[idx] == la;
        PC = pc; PC_VALID = 1'b1;
        step();
        PC_VALID = 1'b0;
        if (hit) begin
            model_hits++;
            exp_instr = l2_word(la, off);
            exp_ready = 1'b1;
            n_checks++;
            if (INSTRUCTION !== exp_instr || READY !== 1'b1 || ADDR_VALID !== 1'b0) begin
                n_fail++;
                $display("FAIL hit pc=%h: instr=%h ready=%b addr_valid=%b, required instr=%h ready=1 addr_valid=0",
                         pc, INSTRUCTION, READY, ADDR_VALID, exp_instr);
            end
        end else begin
            model_misses++;
            exp_ready = 1'b0;
            n_checks++;
            if (READY !== 1'b0 || ADDR_VALID !== 1'b1 || ADDR !== la || DATA_READY !== 1'b0) begin
                n_fail++;
                $display("FAIL miss_request pc=%h: ready=%b addr_valid=%b addr=%h data_ready=%b, required 0/1/%h/0",
                         pc, READY, ADDR_VALID, ADDR, DATA_READY, la);
            end
            // PC churn and stray L2 data must be ignored while the miss is outstanding.
            PC = $urandom; PC_VALID = 1'($urandom_range(0, 1));
            DATA = ~line_for(la); DATA_VALID = 1'b1;
            for (int i = 0; i < addr_wait; i++) begin
                step();
                n_checks++;
                if (ADDR_VALID !== 1'b1 || ADDR !== la || DATA_READY !== 1'b0 || READY !== 1'b0) begin
                    n_fail++;
                    $display("FAIL addr_backpressure cycle %0d: addr_valid=%b addr=%h data_ready=%b ready=%b, required 1/%h/0/0",
                             i, ADDR_VALID, ADDR, DATA_READY, READY, la);
                end
            end
            ADDR_READY = 1'b1;
            step();
            ADDR_READY = 1'b0; DATA_VALID = 1'b0;
            n_checks++;
            if (DATA_READY !== 1'b1 || ADDR_VALID !== 1'b0) begin
                n_fail++;
                $display("FAIL addr_handshake: data_ready=%b addr_valid=%b, required 1/0", DATA_READY, ADDR_VALID);
            end
            if (stall_cycles > 0) STALL = 1'b1;
            for (int i = 0; i < data_wait; i++) step();
            DATA = line_for(la); DATA_VALID = 1'b1;
            step();
            res_valid[idx] = 1'b1;
            res_line[idx]  = la;
            DATA = ~line_for(la);
            n_checks++;
            if (DATA_READY !== 1'b0 || READY !== 1'b0 || ADDR_VALID !== 1'b0) begin
                n_fail++;
                $display("FAIL refill_accept: data_ready=%b ready=%b addr_valid=%b, required 0/0/0",
                         DATA_READY, READY, ADDR_VALID);
            end
            for (int i = 0; i < stall_cycles; i++) begin
                step();
                n_checks++;
                if (READY !== 1'b0 || INSTRUCTION !== exp_instr) begin
                    n_fail++;
                    $display("FAIL respond_stall cycle %0d: instr=%h ready=%b, required %h/0",
                             i, INSTRUCTION, READY, exp_instr);
                end
            end
            STALL = 1'b0;
            step();
            DATA_VALID = 1'b0; PC_VALID = 1'b0;
            exp_instr = l2_word(la, off);
            exp_ready = 1'b1;
            n_checks++;
            if (INSTRUCTION !== exp_instr || READY !== 1'b1) begin
                n_fail++;
                $display("FAIL miss_response pc=%h: instr=%h ready=%b, required %h/1",
                         pc, INSTRUCTION, READY, exp_instr);
            end
        end
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        #1;
        model_reset();
        n_checks++;
        if (INSTRUCTION !== 32'h0 || READY !== 1'b0 || ADDR_VALID !== 1'b0 || ADDR !== 26'h0 || DATA_READY !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: instr=%h ready=%b addr_valid=%b addr=%h data_ready=%b, required all 0",
                     INSTRUCTION, READY, ADDR_VALID, ADDR, DATA_READY);
        end
        step();
        step();
        RST_N = 1'b1;
        step();
    endtask

    task automatic test_cold_miss_and_hit();
        fetch(32'h0000_0000, 0, 0, 0);
        n_checks++;
        if (INSTRUCTION !== 32'h0000_0093) begin
            n_fail++;
            $display("FAIL cold_miss_word0: instr=%h, required 00000093", INSTRUCTION);
        end
        fetch(32'h0000_0004, 0, 0, 0);
        fetch(32'h0000_003C, 0, 0, 0);
    endtask

    task automatic test_conflict();
        fetch(32'h0000_1000, 0, 0, 0);
        fetch(32'h0000_1008, 0, 0, 0);
        fetch(32'h0000_0000, 0, 0, 0);
    endtask

    task automatic test_stall();
        fetch(32'h0000_2008, 1, 2, 3);
        // Stall in IDLE must block a lookup and freeze outputs.
        STALL = 1'b1; PC = 32'h0004_0000; PC_VALID = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (ADDR_VALID !== 1'b0 || READY !== exp_ready || INSTRUCTION !== exp_instr) begin
                n_fail++;
                $display("FAIL idle_stall cycle %0d: addr_valid=%b ready=%b instr=%h, required 0/%b/%h",
                         i, ADDR_VALID, READY, INSTRUCTION, exp_ready, exp_instr);
            end
        end
        STALL = 1'b0; PC_VALID = 1'b0;
    endtask

    task automatic test_backpressure();
        fetch(32'h0003_0040, 5, 1, 0);
    endtask

    task automatic test_idle_hold(input int cycles);
        PC_VALID = 1'b0; PC = $urandom;
        DATA = {16{32'hDEAD_BEEF}}; DATA_VALID = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            step();
            n_checks++;
            if (READY !== exp_ready || INSTRUCTION !== exp_instr || ADDR_VALID !== 1'b0 || DATA_READY !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_hold cycle %0d: ready=%b instr=%h addr_valid=%b data_ready=%b, required %b/%h/0/0",
                         i, READY, INSTRUCTION, ADDR_VALID, DATA_READY, exp_ready, exp_instr);
            end
        end
        DATA_VALID = 1'b0;
    endtask

    task automatic test_reset_mid_refill();
        PC = 32'h0000_2040; PC_VALID = 1'b1;
        step();
        PC_VALID = 1'b0; ADDR_READY = 1'b1;
        step();
        ADDR_READY = 1'b0;
        DATA = line_for(26'h81); DATA_VALID = 1'b1;
        #2;
        RST_N = 1'b0;
        #1;
        model_reset();
        n_checks++;
        if (INSTRUCTION !== 32'h0 || READY !== 1'b0 || ADDR_VALID !== 1'b0 || ADDR !== 26'h0 || DATA_READY !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_refill: instr=%h ready=%b addr_valid=%b addr=%h data_ready=%b, required all 0",
                     INSTRUCTION, READY, ADDR_VALID, ADDR, DATA_READY);
        end
        step();
        DATA_VALID = 1'b0;
        RST_N = 1'b1;
        step();
        fetch(32'h0000_2040, 0, 0, 0);
        fetch(32'h0000_0000, 0, 1, 0);
    endtask

    task automatic test_random(input int n);
        logic [31:0] pc;
        int tags [4] = '{32'h0, 32'h1, 32'h2, 32'hABCDE};
        for (int i = 0; i < n; i++) begin
            pc = (32'(tags[$urandom_range(0, 3)]) << 12) | (32'($urandom_range(0, 7)) << 6)
               | (32'($urandom_range(0, 15)) << 2);
            fetch(pc, $urandom_range(0, 3), $urandom_range(0, 3),
                  ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
            if ($urandom_range(0, 4) == 0) test_idle_hold($urandom_range(1, 3));
        end
    endtask

    initial begin
        test_reset();
        test_cold_miss_and_hit();
        test_idle_hold(2);
        test_conflict();
        test_stall();
        test_backpressure();
        test_reset_mid_refill();
        test_random(150);
`ifdef ICACHE_PERF_COUNTER_EN
        n_checks++;
        if (HIT_COUNT !== 32'(model_hits) || MISS_COUNT !== 32'(model_misses)) begin
            n_fail++;
            $display("FAIL perf_counters: hits=%0d misses=%0d, required %0d/%0d",
                     HIT_COUNT, MISS_COUNT, model_hits, model_misses);
        end
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instruction_cache.md
INSTRUCTION_CACHE -- requirements
Module: instruction_cache

Interface
REQ-001 Parameters (name, default, meaning):
- ADDRESS_WIDTH, 32, PC/instruction width.
- WORD_SIZE, 4, bytes per word.
- WORD_PER_BLOCK, 16, words per line; line = 64 bytes.
- CACHE_DEPTH, 64, number of lines.
- L2_BUS_WIDTH, 32, reserved.
- Derived: BLOCK_WIDTH = 512; BLOCK_ADDRESS_WIDTH = 26.
REQ-002 Ports (name, direction, width, meaning); the clock is single and the reset is asynchronous, active-low:
- CLK  in  1  clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- STALL_INSTRUCTION_CACHE  in  1  freeze outputs and acceptance.
- PC  in  32  fetch byte address.
- PC_VALID  in  1  PC request valid.
- INSTRUCTION  out  32  fetched word.
- INSTRUCTION_CACHE_READY  out  1  INSTRUCTION valid.
- ADDRESS_TO_L2_READY_INSTRUCTION_CACHE  in  1  L2 accepts address.
- ADDRESS_TO_L2_VALID_INSTRUCTION_CACHE  out  1  miss address valid.
- ADDRESS_TO_L2_INSTRUCTION_CACHE  out  26  line address, PC[31:6].
- DATA_FROM_L2_READY_INSTRUCTION_CACHE  out  1  cache accepts line.
- DATA_FROM_L2_VALID_INSTRUCTION_CACHE  in  1  line data valid.
- DATA_FROM_L2_INSTRUCTION_CACHE  in  512  refill line.

Function
REQ-003 The cache SHALL be direct-mapped and read-only:
- Offset = PC[5:2]; index = PC[11:6]; tag = PC[31:12].
- Per line: valid bit, 20-bit tag, 512-bit data.
REQ-004 Word k of a line SHALL occupy bits [511-32k : 480-32k] (word 0 in the MSBs).
REQ-005 The FSM SHALL have states IDLE, REQ, WAIT_DATA and RESPOND.
REQ-006 In IDLE, a lookup SHALL occur on any edge with PC_VALID=1 and STALL=0.
- On a hit: INSTRUCTION <= selected word and READY <= 1; state stays IDLE (1-cycle latency).
REQ-007 On a lookup miss:
- READY <= 0.
- PC is captured into miss_pc.
- State goes to REQ.
REQ-008 In REQ:
- ADDRESS_TO_L2_VALID=1 and ADDRESS_TO_L2 = miss_pc[31:6], held stable until ADDRESS_TO_L2_READY=1 at a rising edge.
- Then state goes to WAIT_DATA.
REQ-009 In WAIT_DATA:
- DATA_FROM_L2_READY=1.
- On DATA_FROM_L2_VALID=1, the line is written, the tag is set and valid <= 1.
- Then state goes to RESPOND.
REQ-010 DATA_FROM_L2_READY and ADDRESS_TO_L2_VALID SHALL be 0 in all other states.
- L2 data arriving outside WAIT_DATA SHALL be ignored.
REQ-011 In RESPOND with STALL=0:
- INSTRUCTION <= word miss_pc[5:2] of the stored line and READY <= 1.
- State goes to IDLE.
- With STALL=1, the FSM remains in RESPOND.
REQ-012 STALL=1 SHALL hold INSTRUCTION and READY unchanged and block new lookups.
- An outstanding L2 handshake SHALL still proceed.
REQ-013 In IDLE with PC_VALID=0, INSTRUCTION and READY SHALL hold.
REQ-014 Only one miss SHALL be outstanding; PC changes during a miss SHALL be ignored.

Reset
REQ-015 RST_N=0 SHALL asynchronously:
- Clear all valid bits.
- Set state to IDLE.
- Set INSTRUCTION=0, READY=0, ADDRESS_TO_L2_VALID=0, ADDRESS_TO_L2=0, DATA_FROM_L2_READY=0.
REQ-016 Reset during REQ or WAIT_DATA SHALL abandon the refill; no line SHALL be written.

Configuration
REQ-017 Macro ICACHE_PERF_COUNTER_EN:
- Defined: adds 32-bit outputs HIT_COUNT and MISS_COUNT.
  - HIT_COUNT increments on each hit lookup; MISS_COUNT increments on each miss lookup.
  - Both saturate at 0xFFFFFFFF and reset to 0.
- Undefined: no such ports or logic; behaviour is otherwise identical.

Verification
REQ-018 Cold miss:
- Stimulus: reset; PC=0x0, PC_VALID=1; L2 address-ready=1; data valid one cycle after the address handshake, with line word0=0x00000093.
- Response: READY=0 after edge1; ADDRESS_VALID=1 with address 0x0; INSTRUCTION=0x00000093 and READY=1 four edges after the request.
REQ-019 Hit:
- Stimulus: after REQ-018, PC=0x4.
- Response: next edge INSTRUCTION = word1, READY=1; no L2 request.
REQ-020 Conflict:
- Stimulus: PC=0x1000 (same index 0, tag 1).
- Response: miss; ADDRESS_TO_L2=0x40; line replaced; then PC=0x0 misses again.
REQ-021 Stall:
- Stimulus: STALL=1 during WAIT_DATA.
- Response: line is filled; INSTRUCTION/READY hold until STALL=0, then the word appears one edge later.
REQ-022 Address backpressure:
- Stimulus: ADDRESS_TO_L2_READY=0 for 5 cycles.
- Response: VALID=1 and address stable all 5 cycles; no data accepted.
REQ-023 Reset mid-refill:
- Stimulus: RST_N=0 in WAIT_DATA, then the same PC.
- Response: all outputs 0; the PC misses again.
